dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port, synchronous-read data memory between the core's load/store path (port 0) and a DMA/debug master (port 1). It grants at most one access per cycle using round-robin, drives the memory's write-enable/address/write-data, and routes the registered read data back to the owning requester one cycle later with a valid strobe. Misaligned word accesses are rejected with an error response and never reach memory.

---
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous-read data memory between
// the core load/store path (port 0) and a DMA/debug master (port 1).
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic              last_grant_q, last_grant_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_owner_q, resp_owner_d;
  logic              resp_is_read_q, resp_is_read_d;
  logic              resp_err_q, resp_err_d;

  logic              any_gnt;
  logic              win1;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              misaligned;

  // Port 1 wins when it is alone, or when both ask and port 0 went last.
  // Grants are held off while reset is high so no access can slip through.
  always_comb begin
    any_gnt    = (m0_req | m1_req) & ~reset;
    win1       = m1_req & (~m0_req | ~last_grant_q);
    sel_we     = win1 ? m1_we    : m0_we;
    sel_addr   = win1 ? m1_addr  : m0_addr;
    sel_wdata  = win1 ? m1_wdata : m0_wdata;
    misaligned = (sel_addr[1:0] != 2'b00);
  end

  assign m0_gnt    = any_gnt & ~win1;
  assign m1_gnt    = any_gnt & win1;
  assign mem_we    = any_gnt & sel_we & ~misaligned;
  assign mem_addr  = any_gnt ? sel_addr  : '0;
  assign mem_wdata = any_gnt ? sel_wdata : '0;

  always_comb begin
    last_grant_d   = any_gnt ? win1 : last_grant_q;
    resp_valid_d   = any_gnt;
    resp_owner_d   = win1;
    resp_is_read_d = ~sel_we;
    resp_err_d     = any_gnt & misaligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q   <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_owner_q   <= 1'b0;
      resp_is_read_q <= 1'b0;
      resp_err_q     <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      resp_valid_q   <= resp_valid_d;
      resp_owner_q   <= resp_owner_d;
      resp_is_read_q <= resp_is_read_d;
      resp_err_q     <= resp_err_d;
    end
  end

  // Memory read data arrives one cycle after the address, aligned with the response register.
  assign m0_rvalid = resp_valid_q & ~resp_owner_q;
  assign m1_rvalid = resp_valid_q & resp_owner_q;
  assign m0_err    = m0_rvalid & resp_err_q;
  assign m1_err    = m1_rvalid & resp_err_q;
  assign m0_rdata  = (m0_rvalid & resp_is_read_q & ~resp_err_q) ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid & resp_is_read_q & ~resp_err_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, hand sequences for contention and reset,
// then random traffic checked against a transaction-level model of grants, responses and memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the arbiter (returns old data on read-during-write).
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[7:2]];
    if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected memory image, who went last, and the one outstanding response.
  logic [31:0] ref_mem [0:63];
  int          m_last;
  bit          m_pv, m_prd, m_perr;
  int          m_po;
  logic [31:0] m_pdata;
  int          g_win;
  logic        s_g0, s_g1, s_mwe, s_rv0, s_rv1, s_e0, s_e1;
  logic [31:0] s_maddr, s_rd0, s_rd1;

  task automatic model_reset();
    m_last = 1; m_pv = 0; m_po = 0; m_prd = 0; m_perr = 0; m_pdata = '0;
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    int win;
    bit mis, we;
    logic [31:0] a, d;
    #1;
    win = -1;
    if (m0_req && m1_req) win = 1 - m_last;
    else if (m0_req)      win = 0;
    else if (m1_req)      win = 1;
    we  = (win == 1) ? m1_we : m0_we;
    a   = (win == 1) ? m1_addr : m0_addr;
    d   = (win == 1) ? m1_wdata : m0_wdata;
    mis = (a % 4) != 0;
    chk({tag, " m0_gnt"}, {31'b0, m0_gnt}, {31'b0, win == 0});
    chk({tag, " m1_gnt"}, {31'b0, m1_gnt}, {31'b0, win == 1});
    chk({tag, " mem_we"}, {31'b0, mem_we}, {31'b0, win >= 0 && we && !mis});
    chk({tag, " mem_addr"}, mem_addr, (win >= 0) ? a : 32'h0);
    chk({tag, " mem_wdata"}, mem_wdata, (win >= 0) ? d : 32'h0);
    chk({tag, " m0_rvalid"}, {31'b0, m0_rvalid}, {31'b0, m_pv && m_po == 0});
    chk({tag, " m1_rvalid"}, {31'b0, m1_rvalid}, {31'b0, m_pv && m_po == 1});
    chk({tag, " m0_err"}, {31'b0, m0_err}, {31'b0, m_pv && m_po == 0 && m_perr});
    chk({tag, " m1_err"}, {31'b0, m1_err}, {31'b0, m_pv && m_po == 1 && m_perr});
    chk({tag, " m0_rdata"}, m0_rdata, (m_pv && m_po == 0 && m_prd && !m_perr) ? m_pdata : 32'h0);
    chk({tag, " m1_rdata"}, m1_rdata, (m_pv && m_po == 1 && m_prd && !m_perr) ? m_pdata : 32'h0);
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_mwe = mem_we; s_maddr = mem_addr;
    s_rv0 = m0_rvalid; s_rv1 = m1_rvalid; s_e0 = m0_err; s_e1 = m1_err;
    s_rd0 = m0_rdata; s_rd1 = m1_rdata;
    $display("%s: req=%b%b gnt=%b%b we=%b addr=%h rv=%b%b err=%b%b rd0=%h rd1=%h",
             tag, m0_req, m1_req, m0_gnt, m1_gnt, mem_we, mem_addr, m0_rvalid, m1_rvalid,
             m0_err, m1_err, m0_rdata, m1_rdata);
    @(posedge clk);
    m_pv = (win >= 0); m_po = (win == 1) ? 1 : 0; m_prd = !we; m_perr = mis;
    m_pdata = ref_mem[a[7:2]];
    if (win >= 0 && we && !mis) ref_mem[a[7:2]] = d;
    if (win >= 0) m_last = win;
    g_win = win;
    @(negedge clk);
  endtask

  typedef struct packed {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic g0, g1, mwe; logic [31:0] maddr;
    logic rv0, rv1, e0, e1; logic [31:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mkv(input logic r0, w0, input logic [31:0] a0, d0,
                               input logic r1, w1, input logic [31:0] a1, d1,
                               input logic g0, g1, mwe, input logic [31:0] maddr,
                               input logic rv0, rv1, e0, e1, input logic [31:0] rd0, rd1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.maddr = maddr;
    v.rv0 = rv0; v.rv1 = rv1; v.e0 = e0; v.e1 = e1; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  vec_t vecs [0:12];
  int   pat [0:5] = '{0, 0, 1, 0, 1, 0};
  logic [31:0] ra0, rd0v, ra1, rd1v;
  logic        rr0, rw0, rr1, rw1;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + i;
    //                 r0 w0 a0     d0            r1 w1 a1     d1            g0 g1 we addr     rv0 rv1 e0 e1 rd0           rd1
    vecs[0]  = mkv(1, 0, 32'h10, 0,            1, 0, 32'h20, 0,            1, 0, 0, 32'h10, 0, 0, 0, 0, 0,            0);
    vecs[1]  = mkv(0, 0, 32'h00, 0,            1, 0, 32'h20, 0,            0, 1, 0, 32'h20, 1, 0, 0, 0, 32'h10000004, 0);
    vecs[2]  = mkv(0, 0, 32'h00, 0,            1, 1, 32'h40, 32'hDEADBEEF, 0, 1, 1, 32'h40, 0, 1, 0, 0, 0,            32'h10000008);
    vecs[3]  = mkv(0, 0, 32'h00, 0,            1, 0, 32'h40, 0,            0, 1, 0, 32'h40, 0, 1, 0, 0, 0,            0);
    vecs[4]  = mkv(1, 1, 32'h42, 32'h12345678, 0, 0, 32'h00, 0,            1, 0, 0, 32'h42, 0, 1, 0, 0, 0,            32'hDEADBEEF);
    vecs[5]  = mkv(1, 0, 32'h40, 0,            0, 0, 32'h00, 0,            1, 0, 0, 32'h40, 1, 0, 1, 0, 0,            0);
    vecs[6]  = mkv(0, 0, 32'h00, 0,            0, 0, 32'h00, 0,            0, 0, 0, 32'h00, 1, 0, 0, 0, 32'hDEADBEEF, 0);
    vecs[7]  = mkv(0, 0, 32'h00, 0,            0, 0, 32'h00, 0,            0, 0, 0, 32'h00, 0, 0, 0, 0, 0,            0);
    vecs[8]  = mkv(0, 0, 32'h00, 0,            0, 0, 32'h00, 0,            0, 0, 0, 32'h00, 0, 0, 0, 0, 0,            0);
    vecs[9]  = mkv(0, 0, 32'h00, 0,            0, 0, 32'h00, 0,            0, 0, 0, 32'h00, 0, 0, 0, 0, 0,            0);
    vecs[10] = mkv(1, 0, 32'h00, 0,            1, 0, 32'h04, 0,            0, 1, 0, 32'h04, 0, 0, 0, 0, 0,            0);
    vecs[11] = mkv(1, 0, 32'h00, 0,            0, 0, 32'h00, 0,            1, 0, 0, 32'h00, 0, 1, 0, 0, 0,            32'h10000001);
    vecs[12] = mkv(0, 0, 32'h00, 0,            0, 0, 32'h00, 0,            0, 0, 0, 32'h00, 1, 0, 0, 0, 32'h10000000, 0);

    // Reset with a store request pending: nothing may be granted or written.
    reset = 1'b1;
    drive(1, 1, 32'h40, 32'hFFFF_FFFF, 1, 0, 32'h20, 0);
    model_reset();
    #2;
    chk("rst m0_gnt", {31'b0, m0_gnt}, 32'h0);
    chk("rst m1_gnt", {31'b0, m1_gnt}, 32'h0);
    chk("rst mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst rvalid", {30'b0, m0_rvalid, m1_rvalid}, 32'h0);
    chk("rst err", {30'b0, m0_err, m1_err}, 32'h0);
    chk("rst rdata", m0_rdata | m1_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
      cycle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl gnt", i), {30'b0, s_g0, s_g1}, {30'b0, vecs[i].g0, vecs[i].g1});
      chk($sformatf("vec%0d tbl mem_we", i), {31'b0, s_mwe}, {31'b0, vecs[i].mwe});
      chk($sformatf("vec%0d tbl mem_addr", i), s_maddr, vecs[i].maddr);
      chk($sformatf("vec%0d tbl rvalid", i), {30'b0, s_rv0, s_rv1}, {30'b0, vecs[i].rv0, vecs[i].rv1});
      chk($sformatf("vec%0d tbl err", i), {30'b0, s_e0, s_e1}, {30'b0, vecs[i].e0, vecs[i].e1});
      chk($sformatf("vec%0d tbl rd0", i), s_rd0, vecs[i].rd0);
      chk($sformatf("vec%0d tbl rd1", i), s_rd1, vecs[i].rd1);
    end
    chk("misaligned store left mem", mem[16], 32'hDEADBEEF);

    // m0 requests for six cycles, m1 joins from the third: grants must be 0,0,1,0,1,0.
    for (int c = 0; c < 6; c++) begin
      drive(1, 0, 32'h08, 0, c >= 2, 0, 32'h0C, 0);
      cycle($sformatf("rr%0d", c));
      chk($sformatf("rr%0d winner", c), {30'b0, s_g1, s_g0}, (pat[c] == 1) ? 32'h2 : 32'h1);
    end

    // Asynchronous reset in the cycle after a load grant discards its response.
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
    cycle("pre-rst load");
    drive(1, 1, 32'h14, 32'hCAFE_F00D, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst m0_rvalid", {31'b0, m0_rvalid}, 32'h0);
    chk("midrst m0_gnt", {31'b0, m0_gnt}, 32'h0);
    chk("midrst mem_we", {31'b0, mem_we}, 32'h0);
    @(posedge clk);
    #1;
    chk("midrst m0_rvalid after edge", {31'b0, m0_rvalid}, 32'h0);
    chk("midrst mem untouched", mem[5], ref_mem[5]);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drive(1, 0, 32'h18, 0, 1, 0, 32'h1C, 0);
    cycle("post-rst contention");
    chk("post-rst m0 wins", {30'b0, s_g0, s_g1}, 32'h2);

    // Random traffic; each requester holds its fields until granted.
    rr0 = 0; rr1 = 0; rw0 = 0; rw1 = 0; ra0 = 0; ra1 = 0; rd0v = 0; rd1v = 0;
    for (int n = 0; n < 400; n++) begin
      if (!rr0 && $urandom_range(0, 9) < 6) begin
        rr0 = 1; rw0 = $urandom_range(0, 1);
        ra0 = {24'b0, $urandom_range(0, 63) << 2} | (($urandom_range(0, 7) == 0) ? 32'h1 : 32'h0);
        rd0v = $urandom;
      end
      if (!rr1 && $urandom_range(0, 9) < 6) begin
        rr1 = 1; rw1 = $urandom_range(0, 1);
        ra1 = {24'b0, $urandom_range(0, 63) << 2} | (($urandom_range(0, 7) == 0) ? 32'h2 : 32'h0);
        rd1v = $urandom;
      end
      drive(rr0, rw0, ra0, rd0v, rr1, rw1, ra1, rd1v);
      cycle($sformatf("rnd%0d", n));
      if (g_win == 0) rr0 = 0;
      if (g_win == 1) rr1 = 0;
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cycle("drain");
    for (int i = 0; i < 64; i++) chk($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
